// File: rtl/spi_puzzle_slave.sv
// SPI mode-0 slave that streams a preloaded puzzle byte store to the master,
// then an end-of-transmission byte, while capturing every MOSI byte.
//
// state | meaning
// LOAD  | accepting puzzle bytes on the load port
// ARMED | store sealed, waiting for slave select
// SHIFT | streaming puzzle bytes followed by one EOT byte
// DONE  | puzzle exhausted, EOT repeats on every further byte
module spi_puzzle_slave #(
  parameter int unsigned MEM_DEPTH  = 32768,
  parameter int unsigned SYNC_FLOPS = 2,
  parameter logic [7:0]  EOT_BYTE   = 8'h04
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  input  logic       spi_ss_n,
  output logic       spi_miso,
  input  logic [7:0] load_byte,
  input  logic       load_valid,
  input  logic       load_last,
  output logic       load_ready,
  output logic [7:0] result_byte,
  output logic       result_valid,
  output logic       puzzle_done
);

  localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned PW = $clog2(MEM_DEPTH + 1);
  localparam logic [PW-1:0] DEPTH_P = PW'(MEM_DEPTH);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  typedef enum logic [1:0] {LOAD, ARMED, SHIFT, DONE} state_t;

  state_t state_q, state_d;
  logic [SYNC_FLOPS-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_FLOPS-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_FLOPS-1:0] ss_sync_q, ss_sync_d;
  logic sclk_prev_q, ss_prev_q;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] len_q, len_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] tx_q, tx_d;
  logic [6:0] rx_q, rx_d;
  logic [7:0] cur_q, cur_d, cur_next;
  logic nxt_pend_q, nxt_pend_d;
  logic [7:0] result_byte_q, result_byte_d;
  logic result_valid_q, result_valid_d;
  logic done_q, done_d;

  logic [7:0] mem [MEM_DEPTH];
  logic [7:0] rdata_q;
  logic rd_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;

  logic sclk_s, mosi_s, ss_s;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [7:0] rx_shift;

  assign sclk_s    = sclk_sync_q[SYNC_FLOPS-1];
  assign mosi_s    = mosi_sync_q[SYNC_FLOPS-1];
  assign ss_s      = ss_sync_q[SYNC_FLOPS-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ss_rise   = ss_s & ~ss_prev_q;
  assign ss_fall   = ~ss_s & ss_prev_q;
  assign rx_shift  = {rx_q, mosi_s};

  assign wr_en   = reset & (state_q == LOAD) & load_valid;
  assign wr_addr = wr_ptr_q[AW-1:0];

  // The raw select also gates MISO so the line drops as soon as the master deselects.
  assign spi_miso     = ((state_q == SHIFT) || (state_q == DONE)) && !ss_s && !spi_ss_n
                        ? tx_q[7] : 1'b0;
  assign load_ready   = (state_q == LOAD);
  assign result_byte  = result_byte_q;
  assign result_valid = result_valid_q;
  assign puzzle_done  = done_q;

  // Write-first forwarding keeps mem[0] current while it is being loaded.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= load_byte;
    if (rd_en) rdata_q <= (wr_en && (wr_addr == rd_addr)) ? load_byte : mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= LOAD;
      sclk_sync_q    <= '0;
      mosi_sync_q    <= '0;
      ss_sync_q      <= '1;
      sclk_prev_q    <= 1'b0;
      ss_prev_q      <= 1'b1;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      len_q          <= '0;
      bit_cnt_q      <= '0;
      tx_q           <= '0;
      rx_q           <= '0;
      cur_q          <= '0;
      nxt_pend_q     <= 1'b0;
      result_byte_q  <= '0;
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      sclk_sync_q    <= sclk_sync_d;
      mosi_sync_q    <= mosi_sync_d;
      ss_sync_q      <= ss_sync_d;
      sclk_prev_q    <= sclk_s;
      ss_prev_q      <= ss_s;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      len_q          <= len_d;
      bit_cnt_q      <= bit_cnt_d;
      tx_q           <= tx_d;
      rx_q           <= rx_d;
      cur_q          <= cur_d;
      nxt_pend_q     <= nxt_pend_d;
      result_byte_q  <= result_byte_d;
      result_valid_q <= result_valid_d;
      done_q         <= done_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    sclk_sync_d    = (sclk_sync_q << 1) | SYNC_FLOPS'(spi_sclk);
    mosi_sync_d    = (mosi_sync_q << 1) | SYNC_FLOPS'(spi_mosi);
    ss_sync_d      = (ss_sync_q << 1) | SYNC_FLOPS'(spi_ss_n);
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    len_d          = len_q;
    bit_cnt_d      = bit_cnt_q;
    tx_d           = tx_q;
    rx_d           = rx_q;
    nxt_pend_d     = 1'b0;
    result_byte_d  = result_byte_q;
    result_valid_d = 1'b0;
    done_d         = done_q;
    rd_en          = 1'b0;
    rd_addr        = '0;

    // cur holds the whole byte in flight so an aborted byte can be resent from bit 7.
    cur_next = cur_q;
    if (nxt_pend_q) cur_next = (rd_ptr_q < len_q) ? rdata_q : EOT_BYTE;
    cur_d = cur_next;

    case (state_q)
      LOAD: begin
        rd_en = 1'b1;
        if (load_valid) begin
          wr_ptr_d = wr_ptr_q + ONE_P;
          if (load_last || (wr_ptr_q + ONE_P == DEPTH_P)) begin
            len_d   = wr_ptr_q + ONE_P;
            state_d = ARMED;
          end
        end
      end
      ARMED: begin
        rd_en = 1'b1;
        if (ss_fall) begin
          state_d   = SHIFT;
          rd_ptr_d  = '0;
          bit_cnt_d = '0;
          tx_d      = rdata_q;
          cur_d     = rdata_q;
        end
      end
      default: begin
        if (ss_rise) begin
          bit_cnt_d = '0;
        end else if (ss_fall) begin
          tx_d = cur_next;
        end else if (!ss_s) begin
          if (sclk_rise) begin
            rx_d      = rx_shift[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              result_byte_d  = rx_shift;
              result_valid_d = 1'b1;
              if (rd_ptr_q == len_q) begin
                done_d  = 1'b1;
                state_d = DONE;
              end else begin
                rd_ptr_d   = rd_ptr_q + ONE_P;
                nxt_pend_d = 1'b1;
                if (rd_ptr_q + ONE_P < len_q) begin
                  rd_en   = 1'b1;
                  rd_addr = AW'(rd_ptr_q + ONE_P);
                end
              end
            end
          end else if (sclk_fall) begin
            tx_d = (bit_cnt_q == 3'd0) ? cur_next : {tx_q[6:0], 1'b0};
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_spi_puzzle_slave.sv
// Scoreboard bench for spi_puzzle_slave: a bit-banged SPI master drives random
// traffic while monitors compare MISO bytes and result strobes to a stream model.
module tb_spi_puzzle_slave;
  localparam int DEPTH = 64;
  localparam logic [7:0] EOT = 8'h04;
  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_sclk, spi_mosi, spi_ss_n, spi_miso;
  logic [7:0] load_byte;
  logic       load_valid, load_last, load_ready;
  logic [7:0] result_byte;
  logic       result_valid, puzzle_done;

  int total = 0;
  int bad = 0;
  int sent = 0;
  logic [7:0] puz[$];
  logic [7:0] exp_res_q[$];
  logic [7:0] exp_miso_q[$];
  logic [7:0] obs_miso_q[$];

  always #5 clk = ~clk;

  spi_puzzle_slave #(.MEM_DEPTH(DEPTH), .SYNC_FLOPS(2), .EOT_BYTE(EOT)) dut (
    .clk(clk), .reset(reset),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_ss_n(spi_ss_n), .spi_miso(spi_miso),
    .load_byte(load_byte), .load_valid(load_valid), .load_last(load_last),
    .load_ready(load_ready), .result_byte(result_byte), .result_valid(result_valid),
    .puzzle_done(puzzle_done)
  );

  task automatic fail(input string name, input logic [31:0] got, input logic [31:0] exp);
    bad++;
    $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) fail(name, got, exp);
  endtask

  // Stream model: completed byte k is puzzle byte k, or EOT once the puzzle is exhausted.
  function automatic logic [7:0] model_byte(input int k);
    return (k < puz.size()) ? puz[k] : EOT;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    check("rst_miso", 32'(spi_miso), 32'd0);
    check("rst_load_ready", 32'(load_ready), 32'd1);
    check("rst_result_byte", 32'(result_byte), 32'd0);
    check("rst_result_valid", 32'(result_valid), 32'd0);
    check("rst_puzzle_done", 32'(puzzle_done), 32'd0);
    reset = 1'b1;
    spi_ss_n = 1'b1;
    spi_sclk = 1'b0;
    repeat (4) @(negedge clk);
    sent = 0;
  endtask

  task automatic load_puzzle(input bit use_last, input bit gaps);
    check("load_ready_idle", 32'(load_ready), 32'd1);
    for (int i = 0; i < puz.size(); i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        load_valid = 1'b0;
        @(negedge clk);
      end
      load_byte  = puz[i];
      load_valid = 1'b1;
      load_last  = use_last && (i == puz.size() - 1);
      @(negedge clk);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    check("load_ready_armed", 32'(load_ready), 32'd0);
  endtask

  task automatic spi_xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int b = 7; b >= 8 - nbits; b--) begin
      spi_mosi = mo[b];
      repeat (HALF) @(negedge clk);
      mi[b] = spi_miso;
      spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic select();
    spi_ss_n = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic deselect();
    repeat (HALF) @(negedge clk);
    spi_ss_n = 1'b1;
    @(negedge clk);
    check("miso_idle", 32'(spi_miso), 32'd0);
    repeat (HALF) @(negedge clk);
  endtask

  task automatic full_byte(input logic [7:0] mo);
    logic [7:0] mi;
    exp_miso_q.push_back(model_byte(sent));
    exp_res_q.push_back(mo);
    spi_xfer(mo, 8, mi);
    obs_miso_q.push_back(mi);
    sent++;
    repeat (2) @(negedge clk);
    check("puzzle_done", 32'(puzzle_done), 32'(sent > puz.size()));
  endtask

  task automatic partial_byte(input int n);
    logic [7:0] mi, mask, ref_b;
    spi_xfer(8'($urandom), n, mi);
    mask  = 8'hFF << (8 - n);
    ref_b = model_byte(sent);
    check("partial_miso", 32'(mi & mask), 32'(ref_b & mask));
  endtask

  initial begin : mon_res
    logic chk_low;
    logic [7:0] want;
    chk_low = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_low) begin
        chk_low = 1'b0;
        check("result_valid_pulse", 32'(result_valid), 32'd0);
      end else if (result_valid) begin
        total++;
        if (exp_res_q.size() == 0) fail("result_unexpected", 32'(result_byte), 32'hFFFF);
        else begin
          want = exp_res_q.pop_front();
          if (result_byte !== want) fail("result_byte", 32'(result_byte), 32'(want));
        end
        chk_low = 1'b1;
      end
    end
  end

  initial begin : mon_miso
    logic [7:0] got, want;
    forever begin
      @(negedge clk);
      if (obs_miso_q.size() > 0) begin
        got = obs_miso_q.pop_front();
        total++;
        if (exp_miso_q.size() == 0) fail("miso_unexpected", 32'(got), 32'hFFFF);
        else begin
          want = exp_miso_q.pop_front();
          if (got !== want) fail("miso_byte", 32'(got), 32'(want));
        end
      end
    end
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    reset = 1'b0;
    spi_sclk = 1'b0; spi_mosi = 1'b0; spi_ss_n = 1'b1;
    load_byte = 8'h00; load_valid = 1'b0; load_last = 1'b0;
    repeat (3) @(negedge clk);
    do_reset();

    // "12\n", MOSI 0xA5 in byte 0, abort inside byte 1, then run past EOT
    puz = '{8'h31, 8'h32, 8'h0A};
    load_puzzle(1'b1, 1'b0);
    select();
    full_byte(8'hA5);
    partial_byte(3);
    deselect();
    select();
    full_byte(8'($urandom));
    full_byte(8'($urandom));
    full_byte(8'($urandom));
    full_byte(8'($urandom));
    deselect();
    select();
    full_byte(8'($urandom));
    partial_byte(5);
    deselect();
    select();
    full_byte(8'($urandom));
    deselect();

    // reset while shifting mid-byte
    do_reset();
    puz.delete();
    for (int i = 0; i < 4; i++) puz.push_back(8'($urandom));
    load_puzzle(1'b1, 1'b1);
    select();
    full_byte(8'($urandom));
    partial_byte(4);
    do_reset();

    // fill the whole store without load_last, then try to load more
    puz.delete();
    for (int i = 0; i < DEPTH; i++) puz.push_back(8'($urandom));
    load_puzzle(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      load_byte  = 8'($urandom);
      load_valid = 1'b1;
      load_last  = i[0];
      @(negedge clk);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    check("load_ready_full", 32'(load_ready), 32'd0);
    select();
    for (int i = 0; i < DEPTH + 2; i++) full_byte(8'($urandom));
    deselect();

    // random puzzles with random aborts
    for (int it = 0; it < 4; it++) begin
      do_reset();
      puz.delete();
      for (int i = 0; i < int'($urandom_range(1, 8)); i++) puz.push_back(8'($urandom));
      load_puzzle(1'b1, 1'b1);
      select();
      for (int k = 0; k < puz.size() + 2; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          partial_byte(int'($urandom_range(1, 7)));
          deselect();
          select();
        end
        full_byte(8'($urandom));
      end
      deselect();
    end

    repeat (20) @(negedge clk);
    check("res_queue_drained", 32'(exp_res_q.size()), 32'd0);
    check("miso_queue_drained", 32'(exp_miso_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
